// File: rtl/lsu_dccm_arb.sv
// Single-port DCCM arbiter: pipe / store-buffer / DMA with two-cycle sub-word RMW.
// Define RV_DMA_STARVE_GUARD_EN to build the DMA starvation counter and freeze request.
module lsu_dccm_arb #(
    parameter int unsigned DMA_MAX_STALL = 8,
    parameter int unsigned CNT_W         = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_override,
    input  logic lsu_freeze_dc3,
    input  logic pipe_req,
    input  logic stbuf_req,
    input  logic stbuf_subword,
    input  logic stbuf_full,
    input  logic dma_req,
    input  logic dma_write,
    input  logic dma_subword,
    output logic pipe_gnt,
    output logic stbuf_gnt,
    output logic dma_gnt,
    output logic dccm_rden,
    output logic dccm_wren,
    output logic rmw_wr,
    output logic pipe_stall,
    output logic dma_starve_freeze,
    output logic arb_clken
);

    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t state;
    logic   owner_dma;
    logic   starve;
    logic   cnt_nz;
    logic   g_pipe, g_sb, g_dma;
    logic   sb_rmw, dma_rmw;

    if (DMA_MAX_STALL < 1 || DMA_MAX_STALL > (2 ** CNT_W) - 1) begin : g_bad_cfg
        $error("lsu_dccm_arb: DMA_MAX_STALL out of range for CNT_W");
    end

`ifdef RV_DMA_STARVE_GUARD_EN
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DMA_MAX_STALL);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (dma_req & ~g_dma) begin
            if (cnt != CNT_MAX)
                cnt <= cnt + CNT_W'(1);
        end else begin
            cnt <= '0;
        end
    end

    always_comb begin
        starve = (cnt == CNT_MAX);
        cnt_nz = (cnt != '0);
    end
`else
    always_comb begin
        starve = 1'b0;
        cnt_nz = 1'b0;
    end
`endif

    always_comb begin
        g_pipe = 1'b0;
        g_sb   = 1'b0;
        g_dma  = 1'b0;
        if (state == IDLE) begin
            if (starve & dma_req)                 g_dma  = 1'b1;
            else if (pipe_req & ~lsu_freeze_dc3)  g_pipe = 1'b1;
            else if (stbuf_full & stbuf_req)      g_sb   = 1'b1;
            else if (dma_req)                     g_dma  = 1'b1;
            else if (stbuf_req)                   g_sb   = 1'b1;
        end
    end

    always_comb begin
        sb_rmw  = g_sb & stbuf_subword;
        dma_rmw = g_dma & dma_write & dma_subword;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner_dma <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sb_rmw | dma_rmw) begin
                        state     <= RMW_WR;
                        owner_dma <= dma_rmw;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The RMW owner keeps its request up through the write phase.
    assert property (@(posedge clk) disable iff (rst)
        (state == RMW_WR) |-> (owner_dma ? dma_req : stbuf_req));

    // Outputs are forced low while reset is held; arb_clken stays live so clocks can run.
    always_comb begin
        pipe_gnt          = ~rst & g_pipe;
        stbuf_gnt         = ~rst & g_sb;
        dma_gnt           = ~rst & g_dma;
        dccm_rden         = ~rst & (g_pipe | (g_dma & ~dma_write) | sb_rmw | dma_rmw);
        dccm_wren         = ~rst & ((state == RMW_WR)
                                    | (g_sb & ~stbuf_subword)
                                    | (g_dma & dma_write & ~dma_subword));
        rmw_wr            = ~rst & (state == RMW_WR);
        pipe_stall        = ~rst & pipe_req & ~lsu_freeze_dc3 & ~g_pipe;
        dma_starve_freeze = ~rst & starve;
        arb_clken         = pipe_req | stbuf_req | dma_req | (state != IDLE)
                            | cnt_nz | clk_override;
    end

endmodule

// File: tb/tb_lsu_dccm_arb.sv
// Self-checking bench for lsu_dccm_arb: directed steps then randomized traffic,
// checked against a behavioural arbitration model.
module tb_lsu_dccm_arb;

    localparam int unsigned MAXS = 8;
`ifdef RV_DMA_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_override = 1'b0;
    logic lsu_freeze_dc3 = 1'b0;
    logic pipe_req = 1'b0, stbuf_req = 1'b0, stbuf_subword = 1'b0, stbuf_full = 1'b0;
    logic dma_req = 1'b0, dma_write = 1'b0, dma_subword = 1'b0;
    logic pipe_gnt, stbuf_gnt, dma_gnt, dccm_rden, dccm_wren, rmw_wr;
    logic pipe_stall, dma_starve_freeze, arb_clken;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: blocked-DMA streak length and pending RMW write.
    int m_cnt = 0;
    bit m_rmw = 1'b0;
    bit m_own_dma = 1'b0;

    always #5 clk = ~clk;

    lsu_dccm_arb #(.DMA_MAX_STALL(MAXS), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .clk_override(clk_override),
        .lsu_freeze_dc3(lsu_freeze_dc3), .pipe_req(pipe_req),
        .stbuf_req(stbuf_req), .stbuf_subword(stbuf_subword),
        .stbuf_full(stbuf_full), .dma_req(dma_req), .dma_write(dma_write),
        .dma_subword(dma_subword), .pipe_gnt(pipe_gnt), .stbuf_gnt(stbuf_gnt),
        .dma_gnt(dma_gnt), .dccm_rden(dccm_rden), .dccm_wren(dccm_wren),
        .rmw_wr(rmw_wr), .pipe_stall(pipe_stall),
        .dma_starve_freeze(dma_starve_freeze), .arb_clken(arb_clken)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic pr, input logic sr, input logic sw, input logic sf,
                         input logic dr, input logic dw, input logic ds);
        pipe_req = pr; stbuf_req = sr; stbuf_subword = sw; stbuf_full = sf;
        dma_req = dr; dma_write = dw; dma_subword = ds;
    endtask

    // Called right after inputs change at a negedge; checks outputs, then steps the model.
    task automatic cycle_check(input string tag);
        bit e_pg, e_sg, e_dg, e_rd, e_wr, e_rw, e_st, e_fz, e_ck;
        bit start, own;
        int w;
        #2;
        {e_pg, e_sg, e_dg, e_rd, e_wr, e_rw, e_st, e_fz} = '0;
        start = 1'b0; own = 1'b0; w = 0;
        if (rst) begin
            m_cnt = 0; m_rmw = 1'b0; m_own_dma = 1'b0;
            e_ck = clk_override | pipe_req | stbuf_req | dma_req;
        end else begin
            e_ck = clk_override | pipe_req | stbuf_req | dma_req | m_rmw | (GUARD && m_cnt != 0);
            e_fz = GUARD && (m_cnt == MAXS);
            if (m_rmw) begin
                e_wr = 1'b1; e_rw = 1'b1;
            end else begin
                if (e_fz && dma_req)                  w = 3;
                else if (pipe_req && !lsu_freeze_dc3) w = 1;
                else if (stbuf_full && stbuf_req)     w = 2;
                else if (dma_req)                     w = 3;
                else if (stbuf_req)                   w = 2;
                case (w)
                    1: begin e_pg = 1'b1; e_rd = 1'b1; end
                    2: begin
                        e_sg = 1'b1;
                        if (stbuf_subword) begin e_rd = 1'b1; start = 1'b1; own = 1'b0; end
                        else e_wr = 1'b1;
                    end
                    3: begin
                        e_dg = 1'b1;
                        if (!dma_write) e_rd = 1'b1;
                        else if (dma_subword) begin e_rd = 1'b1; start = 1'b1; own = 1'b1; end
                        else e_wr = 1'b1;
                    end
                    default: ;
                endcase
            end
            e_st = pipe_req && !lsu_freeze_dc3 && !e_pg;
        end
        chk({tag, ".pipe_gnt"}, pipe_gnt, e_pg);
        chk({tag, ".stbuf_gnt"}, stbuf_gnt, e_sg);
        chk({tag, ".dma_gnt"}, dma_gnt, e_dg);
        chk({tag, ".dccm_rden"}, dccm_rden, e_rd);
        chk({tag, ".dccm_wren"}, dccm_wren, e_wr);
        chk({tag, ".rmw_wr"}, rmw_wr, e_rw);
        chk({tag, ".pipe_stall"}, pipe_stall, e_st);
        chk({tag, ".starve_freeze"}, dma_starve_freeze, e_fz);
        chk({tag, ".arb_clken"}, arb_clken, e_ck);
        if (!rst) begin
            if (dma_req && !e_dg) m_cnt = (m_cnt + 1 > MAXS) ? MAXS : m_cnt + 1;
            else m_cnt = 0;
            m_rmw = start;
            if (start) m_own_dma = own;
        end
    endtask

    initial begin
        @(negedge clk); cycle_check("in_reset");

        @(negedge clk); rst = 1'b0; cycle_check("idle");
        chk("idle_clken", arb_clken, 1'b0);
        @(negedge clk); clk_override = 1'b1; cycle_check("override");
        chk("override_clken", arb_clken, 1'b1);

        @(negedge clk); clk_override = 1'b0; drive(1, 1, 0, 0, 1, 0, 0); cycle_check("all3");
        chk("all3_pipe_wins", pipe_gnt, 1'b1);
        chk("all3_no_stall", pipe_stall, 1'b0);

        @(negedge clk); drive(0, 1, 1, 0, 0, 0, 0); cycle_check("sb_rmw_rd");
        chk("sb_rmw_rd_gnt", stbuf_gnt, 1'b1);
        chk("sb_rmw_rd_rden", dccm_rden, 1'b1);
        @(negedge clk); drive(1, 1, 1, 0, 0, 0, 0); cycle_check("sb_rmw_wr");
        chk("sb_rmw_wr_flag", rmw_wr, 1'b1);
        chk("sb_rmw_wr_stall", pipe_stall, 1'b1);
        @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0); cycle_check("after_rmw");
        chk("after_rmw_pipe", pipe_gnt, 1'b1);

        for (int i = 0; i <= MAXS + 1; i++) begin
            @(negedge clk); drive(1, 0, 0, 0, 1, 0, 0); cycle_check("starve");
            if (GUARD) begin
                if (i < MAXS) chk("starve_pre_gnt", dma_gnt, 1'b0);
                if (i == MAXS) begin
                    chk("starve_freeze_at_max", dma_starve_freeze, 1'b1);
                    chk("starve_dma_gnt", dma_gnt, 1'b1);
                end
                if (i == MAXS + 1) chk("starve_cleared", dma_starve_freeze, 1'b0);
            end else begin
                chk("no_guard_dma_blocked", dma_gnt, 1'b0);
            end
        end

        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0); cycle_check("gap");
        @(negedge clk); drive(0, 1, 0, 1, 1, 0, 0); cycle_check("sb_full");
        chk("sb_full_gnt", stbuf_gnt, 1'b1);
        @(negedge clk); drive(0, 1, 0, 0, 1, 0, 0); cycle_check("sb_notfull");
        chk("sb_notfull_dma", dma_gnt, 1'b1);

        @(negedge clk); drive(0, 1, 1, 0, 0, 0, 0); cycle_check("rst_rmw_rd");
        @(negedge clk); cycle_check("rst_rmw_wr");
        #1 rst = 1'b1;
        #1;
        chk("async_rst_rmw_wr", rmw_wr, 1'b0);
        chk("async_rst_wren", dccm_wren, 1'b0);
        m_rmw = 1'b0; m_cnt = 0;
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0); cycle_check("rst_hold");
        @(negedge clk); rst = 1'b0; drive(0, 1, 0, 0, 0, 0, 0); cycle_check("post_rst");
        chk("post_rst_sb_gnt", stbuf_gnt, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 99) == 0);
            clk_override = ($urandom_range(0, 3) == 0);
            lsu_freeze_dc3 = ($urandom_range(0, 3) == 0);
            drive($urandom_range(0, 9) < 6, $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1));
            if (m_rmw) begin
                if (m_own_dma) dma_req = 1'b1;
                else stbuf_req = 1'b1;
            end
            cycle_check("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
